// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned SUM_W = XLEN + 2;

  // M-extension instructions: funct7 = 0000001 on the OP major opcode
  localparam logic [6:0] M_EXT_FUNCT7 = 7'b0000001;
  localparam logic [6:0] OPCODE_OP    = 7'b0110011;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_FIX  = 2'b10,
    MDU_DONE = 2'b11
  } mdu_state_e;

  // Request latched when an operation is accepted
  typedef struct packed {
    mdu_op_e op;
    logic    neg_a;
    logic    neg_b;
  } mdu_req_t;

  // Decode helper: instruction belongs to the MDU rather than the ALU
  function automatic logic is_mdu_instr(input logic [6:0] funct7, input logic [6:0] opcode);
    return (funct7 == M_EXT_FUNCT7) && (opcode == OPCODE_OP);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  // rs1 is treated as signed for these ops
  function automatic logic op_signed_a(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  // rs2 is treated as signed for these ops
  function automatic logic op_signed_b(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-step radix-2 shift-add multiply
// and restoring divide sharing one 64-bit shift register and adder.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, flush      request (sampled in IDLE) / synchronous abort
//   func3, rs1, rs2   operation select and operands
//   busy, done        high outside IDLE / one-cycle result-valid pulse
//   result            selected, sign-corrected result; held until next start
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  mdu_req_t         req_q, req_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [XLEN-1:0]  opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [XLEN-1:0]  result_q, result_d;

  // Request decode on the raw inputs, used only in IDLE
  mdu_op_e         start_op;
  logic            start_div;
  logic            start_neg_a;
  logic            start_neg_b;
  logic            div_by_zero;
  logic            div_ovf;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  assign start_op    = mdu_op_e'(func3);
  assign start_div   = op_is_div(start_op);
  assign start_neg_a = op_signed_a(start_op) & rs1[XLEN-1];
  assign start_neg_b = op_signed_b(start_op) & rs2[XLEN-1];
  assign abs_a       = start_neg_a ? -rs1 : rs1;
  assign abs_b       = start_neg_b ? -rs2 : rs2;
  assign div_by_zero = start_div && (rs2 == '0);
  assign div_ovf     = ((start_op == MDU_DIV) || (start_op == MDU_REM)) &&
                       (rs1 == INT_MIN) && (rs2 == '1);

  // Shared adder: add multiplicand to upper half, or trial-subtract divisor
  // from the left-shifted remainder (33 bits wide, carry out = no borrow)
  logic [XLEN:0]  add_a;
  logic [XLEN:0]  add_b;
  logic           add_sub;
  logic [SUM_W-1:0] add_sum;
  logic           add_ok;

  always_comb begin
    add_sub = op_is_div(req_q.op);
    add_a   = add_sub ? acc_q[ACC_W-1:XLEN-1] : {1'b0, acc_q[ACC_W-1:XLEN]};
    add_b   = {1'b0, opb_q};
    add_sum = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)} + SUM_W'(add_sub);
    add_ok  = add_sum[SUM_W-1];
  end

  // Sign correction and output selection
  logic [ACC_W-1:0] prod;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  fix_val;

  always_comb begin
    prod = (req_q.neg_a ^ req_q.neg_b) ? -acc_q : acc_q;
    quo  = (req_q.neg_a ^ req_q.neg_b) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = req_q.neg_a ? -acc_q[ACC_W-1:XLEN] : acc_q[ACC_W-1:XLEN];
    case (req_q.op)
      MDU_MUL:                         fix_val = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_val = prod[ACC_W-1:XLEN];
      MDU_DIV, MDU_DIVU:               fix_val = quo;
      default:                         fix_val = rem;
    endcase
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          req_d.op    = start_op;
          req_d.neg_a = start_neg_a;
          req_d.neg_b = start_neg_b;
          cnt_d       = CNT_W'(XLEN - 1);
          if (div_by_zero) begin
            // remainder field = rs1, quotient field = all ones, no correction
            acc_d       = {rs1, {XLEN{1'b1}}};
            req_d.neg_a = 1'b0;
            req_d.neg_b = 1'b0;
            state_d     = MDU_FIX;
          end else if (div_ovf) begin
            acc_d       = {{XLEN{1'b0}}, INT_MIN};
            req_d.neg_a = 1'b0;
            req_d.neg_b = 1'b0;
            state_d     = MDU_FIX;
          end else if (start_div) begin
            acc_d   = {{XLEN{1'b0}}, abs_a};
            opb_d   = abs_b;
            state_d = MDU_CALC;
          end else begin
            acc_d   = {{XLEN{1'b0}}, abs_b};
            opb_d   = abs_a;
            state_d = MDU_CALC;
          end
        end
      end

      MDU_CALC: begin
        if (op_is_div(req_q.op)) begin
          if (add_ok) acc_d = {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else        acc_d = {acc_q[ACC_W-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {add_sum[XLEN:0], acc_q[XLEN-1:1]};
          else          acc_d = {1'b0, acc_q[ACC_W-1:1]};
        end
        if (cnt_q == '0) state_d = MDU_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end

      MDU_FIX: begin
        result_d = fix_val;
        state_d  = MDU_DONE;
      end

      default: state_d = MDU_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start
    if (flush) begin
      state_d  = MDU_IDLE;
      result_d = result_q;
    end

    busy_d = (state_d != MDU_IDLE);
    done_d = (state_d == MDU_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDU_IDLE;
      req_q    <= '{op: MDU_MUL, neg_a: 1'b0, neg_b: 1'b0};
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit in the execute stage, alongside the single-cycle ALU. Decode routes instructions with funct7 = 0000001 and opcode OP here instead of through ALU-select decoding. The unit takes funct3 and both operands, runs a 32-step shift-add or restoring-divide sequence, and returns a 32-bit result with a one-cycle done pulse. Hazard logic stalls the pipeline while busy is high.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a new operation; sampled only in IDLE
- flush  in  1  synchronous abort of the in-flight operation
- func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  operand A (multiplicand / dividend)
- rs2  in  XLEN  operand B (multiplier / divisor)
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse; result valid in that cycle
- result  out  XLEN  final value; holds until the next accepted start

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - start=1 latches func3, the signedness of each operand, and the absolute values |rs1| and |rs2| (unsigned ops pass operands through unchanged).
  - Step counter loads 31.
  - Next state is CALC, except for a special case, which goes directly to FIX.
- **CALC**, multiply (radix-2)
  - If the multiplier LSB is 1, add the multiplicand to the upper half of a 64-bit accumulator.
  - Shift the accumulator right by 1.
- **CALC**, divide (restoring)
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor; if the result is non-negative, keep it and set quo[0].
- **CALC** leaves to FIX when the counter reaches 0 (32 steps).
- **FIX** applies sign correction and selects the output:
  - Product is negated if exactly one operand is signed-negative.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Selection: MUL takes low 32 bits; MULH/MULHSU/MULHU take high 32 bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Registers result. Next state is DONE.
- **DONE**: done=1 for one cycle, then IDLE.
- Special cases are detected in IDLE and bypass CALC:
  - Divisor = 0: quotient = 0xFFFFFFFF; remainder = rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Width rule: the 64-bit product is computed on magnitudes, then negated as 64 bits. For MULHSU only rs1 is treated as signed.
- start while busy is ignored; it is neither queued nor an error.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, counter 0.
- start accepted at edge t:
  - busy is high from t+1.
  - CALC occupies t+1 … t+32, FIX is at t+33, done is high in cycle t+34.
  - busy falls at t+35.
- Special cases: FIX at t+1, done at t+2.
- Back-to-back: start may be asserted in the cycle after done. That is the IDLE cycle; it is accepted at that edge.
- flush=1 in any state returns to IDLE at the next edge:
  - done is suppressed; result is unchanged.
  - flush with start in the same IDLE cycle: flush wins and nothing is accepted.
- rst_n low at any point forces reset values immediately, independent of clk. The operation is lost.
- Operands need only be stable in the accepting cycle.

## Structure
- defines.v gains:
  - `MDU_MUL` … `MDU_REMU` func3 constants.
  - `MDU_IDLE`/`MDU_CALC`/`MDU_FIX`/`MDU_DONE` 2-bit state encodings.
  - `IR_funct7`-based M-extension detect constant.
- Single module with no sub-module. Multiply and divide share the 64-bit shift register and 33-bit adder/subtractor.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD (-3) → result 0xFFFFFFEB; done exactly 34 cycles after the start edge; busy high for 34 cycles.
- MULH, 0x80000000×0x80000000 → 0x40000000. MULHSU, 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF, with done 2 cycles after start. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Start MUL, then flush 10 cycles later → no done; busy low the next cycle; result keeps its old value. A new DIVU 9/3 accepted immediately after → 3.
- Start, then assert rst_n=0 mid-CALC asynchronously → busy, done and result are 0 before the next edge. A start pulse during busy is ignored: exactly one done occurs.
